// File: rtl/ahb_mem_slave.sv
// AHB slave responder: word-addressed RAM with programmable wait states, ERROR on illegal
// addresses and read-after-write forwarding. Define AHB_SLV_RAND_WAIT_EN for LFSR-driven extra waits.
module ahb_mem_slave #(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int MEM_DEPTH   = 256,
    parameter int WAIT_STATES = 1
) (
    input  logic              HCLK,
    input  logic              HRESETn,
    input  logic              HSEL,
    input  logic [ADDR_W-1:0] HADDR,
    input  logic [1:0]        HTRANS,
    input  logic              HWRITE,
    input  logic [DATA_W-1:0] HWDATA,
    input  logic              HREADY_IN,
    output logic              HREADYOUT,
    output logic [1:0]        HRESP,
    output logic [DATA_W-1:0] HRDATA
);
    // state  | meaning
    // S_IDLE | no data phase in flight, zero-wait OKAY
    // S_WAIT | legal transfer stalled, counting down wait cycles
    // S_DATA | final data-phase cycle, write commits at its closing edge
    // S_ERR1 | first ERROR cycle (HREADYOUT low)
    // S_ERR2 | second ERROR cycle (HREADYOUT high), may accept next transfer
    localparam int                IDX_W     = $clog2(MEM_DEPTH);
    localparam logic [ADDR_W-1:0] MEM_BYTES = ADDR_W'(MEM_DEPTH * 4);
    localparam logic [4:0]        BASE_WAIT = 5'(WAIT_STATES);

    typedef enum logic [2:0] {S_IDLE, S_WAIT, S_DATA, S_ERR1, S_ERR2} state_t;

    state_t            r_state, w_state_nxt;
    logic [3:0]        r_cnt, w_cnt_nxt;
    logic [IDX_W-1:0]  r_idx;
    logic              r_write;
    logic [DATA_W-1:0] r_rdata;
    logic [DATA_W-1:0] r_mem [MEM_DEPTH];

    logic              w_open, w_accept, w_illegal, w_legal;
    logic [IDX_W-1:0]  w_idx;
    logic [4:0]        w_wait_tot, w_wait_m1;
    logic              w_unused;

    assign w_open    = (r_state == S_IDLE) || (r_state == S_DATA) || (r_state == S_ERR2);
    assign w_accept  = w_open & HSEL & HREADY_IN & HTRANS[1];
    assign w_illegal = (HADDR[1:0] != 2'b00) || (HADDR >= MEM_BYTES);
    assign w_legal   = w_accept & ~w_illegal;
    assign w_idx     = HADDR[IDX_W+1:2];
    assign w_unused  = HTRANS[0];

`ifdef AHB_SLV_RAND_WAIT_EN
    logic [7:0] r_lfsr;

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn)
            r_lfsr <= 8'hA5;
        else if (w_accept)
            r_lfsr <= {r_lfsr[6:0], r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3]};
    end

    assign w_wait_tot = BASE_WAIT + {3'b000, r_lfsr[1:0]};
`else
    assign w_wait_tot = BASE_WAIT;
`endif
    assign w_wait_m1 = w_wait_tot - 5'd1;

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            r_state <= S_IDLE;
            r_cnt   <= 4'd0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        HREADYOUT   = 1'b1;
        HRESP       = 2'b00;
        case (r_state)
            S_WAIT: begin
                HREADYOUT = 1'b0;
                if (r_cnt == 4'd0)
                    w_state_nxt = S_DATA;
                else
                    w_cnt_nxt = r_cnt - 4'd1;
            end
            S_ERR1: begin
                HREADYOUT   = 1'b0;
                HRESP       = 2'b01;
                w_state_nxt = S_ERR2;
            end
            S_ERR2:  HRESP = 2'b01;
            default: ;
        endcase
        if (w_open) begin
            w_state_nxt = S_IDLE;
            if (w_accept) begin
                if (w_illegal)
                    w_state_nxt = S_ERR1;
                else if (w_wait_tot == 5'd0)
                    w_state_nxt = S_DATA;
                else begin
                    w_state_nxt = S_WAIT;
                    // extra LFSR waits can push past 15; the 4-bit counter saturates
                    w_cnt_nxt   = w_wait_m1[4] ? 4'hF : w_wait_m1[3:0];
                end
            end
        end
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            r_idx   <= '0;
            r_write <= 1'b0;
            r_rdata <= '0;
        end else begin
            if (w_legal) begin
                r_idx   <= w_idx;
                r_write <= HWRITE;
            end
            // zero-wait read may land on the word a DATA-phase write is committing right now
            if (w_legal && !HWRITE && (w_wait_tot == 5'd0))
                r_rdata <= ((r_state == S_DATA) && r_write && (r_idx == w_idx)) ? HWDATA : r_mem[w_idx];
            else if ((r_state == S_WAIT) && (r_cnt == 4'd0) && !r_write)
                r_rdata <= r_mem[r_idx];
        end
    end

    always_ff @(posedge HCLK) begin
        if ((r_state == S_DATA) && r_write)
            r_mem[r_idx] <= HWDATA;
    end

    assign HRDATA = r_rdata;

endmodule

// File: tb/tb_ahb_mem_slave.sv
// Directed bench for ahb_mem_slave: two instances (1 and 0 wait states) on a shared bus,
// expected data-phase results queued at address acceptance and checked at completion.
module tb_ahb_mem_slave;
    logic        HCLK = 1'b0;
    logic        HRESETn;
    logic [31:0] haddr, hwdata;
    logic [1:0]  htrans;
    logic        hwrite;
    logic        sel0, sel1;
    logic        rdy0, rdy1;
    logic [1:0]  resp0, resp1;
    logic [31:0] rdata0, rdata1;

    always #5 HCLK = ~HCLK;

    ahb_mem_slave #(.WAIT_STATES(1)) u_dut1 (
        .HCLK(HCLK), .HRESETn(HRESETn), .HSEL(sel1), .HADDR(haddr), .HTRANS(htrans),
        .HWRITE(hwrite), .HWDATA(hwdata), .HREADY_IN(rdy1), .HREADYOUT(rdy1),
        .HRESP(resp1), .HRDATA(rdata1));

    ahb_mem_slave #(.WAIT_STATES(0)) u_dut0 (
        .HCLK(HCLK), .HRESETn(HRESETn), .HSEL(sel0), .HADDR(haddr), .HTRANS(htrans),
        .HWRITE(hwrite), .HWDATA(hwdata), .HREADY_IN(rdy0), .HREADYOUT(rdy0),
        .HRESP(resp0), .HRDATA(rdata0));

    typedef struct {
        logic [1:0]  trans;
        logic [31:0] addr;
        logic        wr;
        logic [31:0] wdata;
    } beat_t;

    typedef struct {
        logic [1:0]  resp;
        int          waits;
        logic [7:0]  idx;
        bit          commit;
        logic [31:0] wdata;
        logic [31:0] rdata;
    } exp_t;

    beat_t       beats[$];
    exp_t        sb[$];
    logic [31:0] mem_m [2][256];
    logic [31:0] rd_m  [2];
    int          ws    [2] = '{0, 1};
    int          n_checks = 0;
    int          n_fail   = 0;

    function automatic logic get_rdy(input int w);
        return (w == 1) ? rdy1 : rdy0;
    endfunction

    function automatic logic [1:0] get_resp(input int w);
        return (w == 1) ? resp1 : resp0;
    endfunction

    function automatic logic [31:0] get_rdata(input int w);
        return (w == 1) ? rdata1 : rdata0;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic add(input logic [1:0] t, input logic [31:0] a, input logic wr, input logic [31:0] d);
        beat_t b;
        b.trans = t; b.addr = a; b.wr = wr; b.wdata = d;
        beats.push_back(b);
    endtask

    task automatic drive_idle();
        sel0 = 1'b0; sel1 = 1'b0; htrans = 2'b00; hwrite = 1'b0; haddr = 32'h0;
    endtask

    task automatic present(input int w, input beat_t b);
        sel1 = (w == 1); sel0 = (w == 0);
        haddr = b.addr; htrans = b.trans; hwrite = b.wr;
    endtask

    function automatic exp_t make_exp(input int w, input beat_t b);
        exp_t e;
        bit   act, ill;
        act      = b.trans[1];
        ill      = act && ((b.addr[1:0] != 2'b00) || (b.addr >= 32'h400));
        e.resp   = ill ? 2'b01 : 2'b00;
        e.waits  = !act ? 0 : (ill ? 1 : ws[w]);
        e.idx    = b.addr[9:2];
        e.commit = act && !ill && b.wr;
        e.wdata  = b.wdata;
        e.rdata  = (act && !ill && !b.wr) ? mem_m[w][e.idx] : rd_m[w];
        return e;
    endfunction

    // Pipelined master: called and returns at posedge+1 with the slave ready.
    task automatic run_seq(input int w, input string tag);
        beat_t b;
        exp_t  e;
        bit    have_b, pend;
        int    stall, cyc;
        logic  r;
        pend = 0; stall = 0; cyc = 0;
        have_b = (beats.size() != 0);
        if (have_b) begin b = beats.pop_front(); present(w, b); end
        else drive_idle();
        while (have_b || pend) begin
            @(negedge HCLK);
            r = get_rdy(w);
            if (pend && !r) begin
                stall++;
                chk({tag, " stall resp"}, 32'(get_resp(w)), 32'(sb[0].resp));
                chk({tag, " stall rdata"}, get_rdata(w), rd_m[w]);
            end else if (pend && r) begin
                e = sb.pop_front();
                chk({tag, " waits"}, 32'(stall), 32'(e.waits));
                chk({tag, " resp"}, 32'(get_resp(w)), 32'(e.resp));
                chk({tag, " rdata"}, get_rdata(w), e.rdata);
                if (e.commit) mem_m[w][e.idx] = e.wdata;
                rd_m[w] = e.rdata;
                pend = 0; stall = 0;
            end
            if (r && have_b) begin
                sb.push_back(make_exp(w, b));
                pend = 1;
            end
            @(posedge HCLK); #1;
            if (r && have_b) begin
                hwdata = b.wr ? b.wdata : $urandom();
                have_b = (beats.size() != 0);
                if (have_b) begin b = beats.pop_front(); present(w, b); end
                else drive_idle();
            end
            cyc++;
            if (cyc > 200) begin
                n_checks++; n_fail++;
                $display("FAIL %s timeout: observed no completion, required completion within 200 cycles", tag);
                sb.delete(); beats.delete(); drive_idle();
                break;
            end
        end
    endtask

    initial begin
        HRESETn = 1'b1;
        hwdata  = 32'h0;
        drive_idle();
        rd_m[0] = 32'h0; rd_m[1] = 32'h0;
        #1 HRESETn = 1'b0;

        // T1 reset
        repeat (2) @(posedge HCLK);
        @(negedge HCLK);
        chk("T1 rst rdy1", 32'(rdy1), 32'h1);
        chk("T1 rst resp1", 32'(resp1), 32'h0);
        chk("T1 rst rdata1", rdata1, 32'h0);
        chk("T1 rst rdy0", 32'(rdy0), 32'h1);
        chk("T1 rst rdata0", rdata0, 32'h0);
        HRESETn = 1'b1;
        repeat (2) @(posedge HCLK);
        @(negedge HCLK);
        chk("T1 post rdy1", 32'(rdy1), 32'h1);
        chk("T1 post resp1", 32'(resp1), 32'h0);
        chk("T1 post rdata1", rdata1, 32'h0);
        @(posedge HCLK); #1;

        // preload words used later as untouched references
        add(2'b10, 32'h40, 1'b1, 32'h0BADF00D);
        add(2'b10, 32'h00, 1'b1, 32'h11112222);
        run_seq(1, "PRE");

        // T2 write then read with one wait state
        add(2'b10, 32'h10, 1'b1, 32'hDEADBEEF);
        add(2'b10, 32'h10, 1'b0, 32'h0);
        run_seq(1, "T2");

        // T3 misaligned / out of range, then confirm word 0 untouched
        add(2'b10, 32'h402, 1'b0, 32'h0);
        add(2'b10, 32'h400, 1'b0, 32'h0);
        add(2'b10, 32'h400, 1'b1, 32'hFFFFFFFF);
        add(2'b10, 32'h000, 1'b0, 32'h0);
        add(2'b10, 32'h402, 1'b0, 32'h0);
        run_seq(1, "T3");

        // T4 INCR4 write with a BUSY beat, then readback
        add(2'b10, 32'h20, 1'b1, 32'hA0A0A0A0);
        add(2'b11, 32'h24, 1'b1, 32'hA1A1A1A1);
        add(2'b01, 32'h28, 1'b1, 32'h0);
        add(2'b11, 32'h28, 1'b1, 32'hA2A2A2A2);
        add(2'b11, 32'h2C, 1'b1, 32'hA3A3A3A3);
        add(2'b10, 32'h20, 1'b0, 32'h0);
        add(2'b11, 32'h24, 1'b0, 32'h0);
        add(2'b11, 32'h28, 1'b0, 32'h0);
        add(2'b11, 32'h2C, 1'b0, 32'h0);
        run_seq(1, "T4");

        // T5 zero-wait RAW forwarding, plus a different-word read that must not forward
        add(2'b10, 32'h30, 1'b1, 32'h12345678);
        add(2'b10, 32'h30, 1'b0, 32'h0);
        add(2'b10, 32'h34, 1'b1, 32'h9ABCDEF0);
        add(2'b10, 32'h30, 1'b0, 32'h0);
        add(2'b10, 32'h34, 1'b0, 32'h0);
        run_seq(0, "T5");

        // T6 reset during the wait cycle of a write
        begin
            beat_t b;
            b.trans = 2'b10; b.addr = 32'h40; b.wr = 1'b1; b.wdata = 32'hAAAA5555;
            present(1, b);
            @(posedge HCLK); #1;
            hwdata = 32'hAAAA5555;
            drive_idle();
            chk("T6 in wait rdy1", 32'(rdy1), 32'h0);
            #1 HRESETn = 1'b0;
            #1;
            chk("T6 rst rdy1", 32'(rdy1), 32'h1);
            chk("T6 rst resp1", 32'(resp1), 32'h0);
            chk("T6 rst rdata1", rdata1, 32'h0);
            repeat (2) @(posedge HCLK);
            @(negedge HCLK);
            HRESETn = 1'b1;
            rd_m[0] = 32'h0; rd_m[1] = 32'h0;
            @(posedge HCLK); #1;
        end
        add(2'b10, 32'h40, 1'b0, 32'h0);
        run_seq(1, "T6");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed simulation still running, required end before 200000");
        $fatal(1);
    end

endmodule
